// File: rtl/udp_cmd_pkg.sv
// udp_cmd_pkg: shared constants and types for the UDP command-frame parser.
//   - opcode values carried in the OPCODE byte
//   - error codes reported on err_code_out
//   - parser FSM state encoding
//   - default frame start marker
package udp_cmd_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned TADDR_W    = 34;
  localparam int unsigned MAX_LEN_W  = 16;
  localparam int unsigned FCOUNT_W   = 16;
  localparam int unsigned ERR_CODE_W = 2;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [BYTE_W-1:0] OP_SET_ADDR    = 8'h01;
  localparam logic [BYTE_W-1:0] OP_SELF_CHECK  = 8'h02;
  localparam logic [BYTE_W-1:0] OP_SET_MAX_LEN = 8'h03;

  // Payload lengths each opcode requires
  localparam logic [BYTE_W-1:0] LEN_SET_ADDR    = 8'd5;
  localparam logic [BYTE_W-1:0] LEN_SELF_CHECK  = 8'd0;
  localparam logic [BYTE_W-1:0] LEN_SET_MAX_LEN = 8'd2;

  localparam logic [ERR_CODE_W-1:0] ERR_NONE     = 2'd0;
  localparam logic [ERR_CODE_W-1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [ERR_CODE_W-1:0] ERR_LEN_OP   = 2'd2;
  localparam logic [ERR_CODE_W-1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPCODE  = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4
  } state_t;

endpackage

// File: rtl/udp_cmd_parser.sv
// udp_cmd_parser: byte-serial host command-frame parser (clk_udp domain).
// Frame: SYNC, OPCODE, LEN, LEN payload bytes, CHK (XOR of OPCODE, LEN, payload).
// Ports:
//   clk_udp, reset_udp   - clock, synchronous active-high reset
//   cmd_in, cmd_valid_in - command byte stream, no backpressure
//   taddr_out            - SRIO target address (SET_ADDR)
//   taddr_update_out     - one-cycle pulse when taddr_out changes
//   self_check_out       - one-cycle self-check request (SELF_CHECK)
//   max_len_out          - SRIO burst byte limit (SET_MAX_LEN)
//   err_out              - one-cycle error pulse
//   err_code_out         - last error: 1 checksum, 2 length/opcode, 3 timeout
//   frame_count_out      - good frames accepted, wraps
module udp_cmd_parser
  import udp_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_PAYLOAD    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] MAX_LEN_RESET  = 16'd256
) (
  input  logic                  clk_udp,
  input  logic                  reset_udp,
  input  logic [BYTE_W-1:0]     cmd_in,
  input  logic                  cmd_valid_in,
  output logic [TADDR_W-1:0]    taddr_out,
  output logic                  taddr_update_out,
  output logic                  self_check_out,
  output logic [MAX_LEN_W-1:0]  max_len_out,
  output logic                  err_out,
  output logic [ERR_CODE_W-1:0] err_code_out,
  output logic [FCOUNT_W-1:0]   frame_count_out
);

  // Payload register holds the largest legal payload; SET_ADDR needs at least 5 bytes.
  localparam int unsigned PAYLOAD_W = BYTE_W * MAX_PAYLOAD;
  localparam int unsigned TMO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                  r_state;
  logic [BYTE_W-1:0]       r_opcode;
  logic [BYTE_W-1:0]       r_len;
  logic [BYTE_W-1:0]       r_xor;
  logic [BYTE_W-1:0]       r_cnt;
  logic [PAYLOAD_W-1:0]    r_payload;
  logic [TMO_W-1:0]        r_tmo;

  logic [TADDR_W-1:0]      r_taddr;
  logic                    r_taddr_update;
  logic                    r_self_check;
  logic [MAX_LEN_W-1:0]    r_max_len;
  logic                    r_err;
  logic [ERR_CODE_W-1:0]   r_err_code;
  logic [FCOUNT_W-1:0]     r_frame_count;

  logic                    w_cmd_legal;
  logic                    w_tmo_expire;
  logic [TADDR_W-1:0]      w_new_taddr;
  logic [MAX_LEN_W-1:0]    w_new_max_len;

  assign w_new_taddr   = r_payload[TADDR_W-1:0];
  assign w_new_max_len = r_payload[MAX_LEN_W-1:0];

  // Opcode/length legality of the frame being closed by the CHK byte
  always_comb begin
    w_cmd_legal = 1'b0;
    case (r_opcode)
      OP_SET_ADDR:    w_cmd_legal = (r_len == LEN_SET_ADDR);
      OP_SELF_CHECK:  w_cmd_legal = (r_len == LEN_SELF_CHECK);
      OP_SET_MAX_LEN: w_cmd_legal = (r_len == LEN_SET_MAX_LEN) && (w_new_max_len != '0);
      default:        w_cmd_legal = 1'b0;
    endcase
  end

  // A byte arriving on the expiry cycle wins over the timeout
  assign w_tmo_expire = (r_state != ST_IDLE) && !cmd_valid_in &&
                        (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Parser FSM, datapath and registered outputs
  always_ff @(posedge clk_udp) begin
    if (reset_udp) begin
      r_state        <= ST_IDLE;
      r_opcode       <= '0;
      r_len          <= '0;
      r_xor          <= '0;
      r_cnt          <= '0;
      r_payload      <= '0;
      r_tmo          <= '0;
      r_taddr        <= '0;
      r_taddr_update <= 1'b0;
      r_self_check   <= 1'b0;
      r_max_len      <= MAX_LEN_RESET;
      r_err          <= 1'b0;
      r_err_code     <= ERR_NONE;
      r_frame_count  <= '0;
    end else begin
      r_taddr_update <= 1'b0;
      r_self_check   <= 1'b0;
      r_err          <= 1'b0;

      if (w_tmo_expire) begin
        r_state    <= ST_IDLE;
        r_tmo      <= '0;
        r_err      <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
      end else if (cmd_valid_in) begin
        r_tmo <= '0;
        case (r_state)
          ST_IDLE: begin
            if (cmd_in == SYNC_BYTE) begin
              r_state   <= ST_OPCODE;
              r_payload <= '0;
            end
          end

          ST_OPCODE: begin
            r_opcode <= cmd_in;
            r_xor    <= cmd_in;
            r_state  <= ST_LEN;
          end

          ST_LEN: begin
            r_len <= cmd_in;
            r_xor <= r_xor ^ cmd_in;
            if (cmd_in > BYTE_W'(MAX_PAYLOAD)) begin
              r_state    <= ST_IDLE;
              r_err      <= 1'b1;
              r_err_code <= ERR_LEN_OP;
            end else if (cmd_in == '0) begin
              r_state <= ST_CHECK;
            end else begin
              r_cnt   <= cmd_in;
              r_state <= ST_PAYLOAD;
            end
          end

          ST_PAYLOAD: begin
            // Big-endian: earlier bytes migrate toward the MSBs
            r_payload <= PAYLOAD_W'({r_payload, cmd_in});
            r_xor     <= r_xor ^ cmd_in;
            r_cnt     <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            r_state <= ST_IDLE;
            if (cmd_in != r_xor) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CHECKSUM;
            end else if (!w_cmd_legal) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_LEN_OP;
            end else begin
              r_frame_count <= r_frame_count + 16'd1;
              case (r_opcode)
                OP_SET_ADDR: begin
                  if (w_new_taddr != r_taddr) begin
                    r_taddr        <= w_new_taddr;
                    r_taddr_update <= 1'b1;
                  end
                end
                OP_SELF_CHECK:  r_self_check <= 1'b1;
                OP_SET_MAX_LEN: r_max_len    <= w_new_max_len;
                default:        r_self_check <= 1'b0;
              endcase
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

  assign taddr_out        = r_taddr;
  assign taddr_update_out = r_taddr_update;
  assign self_check_out   = r_self_check;
  assign max_len_out      = r_max_len;
  assign err_out          = r_err;
  assign err_code_out     = r_err_code;
  assign frame_count_out  = r_frame_count;

endmodule

// File: tb/tb_udp_cmd_parser.sv
// tb_udp_cmd_parser: self-checking bench for udp_cmd_parser.
// Expected pulses (taddr update, self check, error) are queued as frames are
// driven; a monitor pops and compares them whenever the DUT pulses.
module tb_udp_cmd_parser;

  localparam int unsigned TMO        = 1024;
  localparam logic [15:0] MAXLEN_RST = 16'd256;
  localparam int K_TADDR = 0;
  localparam int K_SELF  = 1;
  localparam int K_ERR   = 2;
  localparam int DRAIN_BUDGET = 16;

  typedef struct {
    int          kind;
    logic [33:0] val;
  } ev_t;

  logic        clk_udp = 1'b0;
  logic        reset_udp;
  logic [7:0]  cmd_in;
  logic        cmd_valid_in;
  logic [33:0] taddr_out;
  logic        taddr_update_out;
  logic        self_check_out;
  logic [15:0] max_len_out;
  logic        err_out;
  logic [1:0]  err_code_out;
  logic [15:0] frame_count_out;

  ev_t  q_exp[$];
  ev_t  obs[$];
  ev_t  e_pop;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] exp_count = 16'd0;

  udp_cmd_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_PAYLOAD    (8),
    .TIMEOUT_CYCLES (TMO),
    .MAX_LEN_RESET  (MAXLEN_RST)
  ) dut (
    .clk_udp          (clk_udp),
    .reset_udp        (reset_udp),
    .cmd_in           (cmd_in),
    .cmd_valid_in     (cmd_valid_in),
    .taddr_out        (taddr_out),
    .taddr_update_out (taddr_update_out),
    .self_check_out   (self_check_out),
    .max_len_out      (max_len_out),
    .err_out          (err_out),
    .err_code_out     (err_code_out),
    .frame_count_out  (frame_count_out)
  );

  always #5 clk_udp = ~clk_udp;

  // Pulse monitor: every observed pulse must match the head of the scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk_udp);
      if (reset_udp === 1'b0) begin
        obs.delete();
        if (taddr_update_out === 1'b1) obs.push_back('{kind: K_TADDR, val: taddr_out});
        if (self_check_out === 1'b1)   obs.push_back('{kind: K_SELF,  val: 34'd0});
        if (err_out === 1'b1)          obs.push_back('{kind: K_ERR,   val: 34'(err_code_out)});
        foreach (obs[i]) begin
          n_tests++;
          if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got kind %0d val %h, want no pulse", obs[i].kind, obs[i].val);
          end else begin
            e_pop = q_exp.pop_front();
            if (obs[i].kind !== e_pop.kind || obs[i].val !== e_pop.val) begin
              n_fail++;
              $display("FAIL pulse_match: got kind %0d val %h, want kind %0d val %h",
                       obs[i].kind, obs[i].val, e_pop.kind, e_pop.val);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    cmd_in       = b;
    cmd_valid_in = 1'b1;
    @(negedge clk_udp);
    cmd_valid_in = 1'b0;
    cmd_in       = 8'h00;
  endtask

  task automatic expect_ev(input int kind, input logic [33:0] val);
    q_exp.push_back('{kind: kind, val: val});
  endtask

  // Bounded wait for the monitor to consume all expected pulses
  task automatic drain(output int left);
    int waited = 0;
    @(negedge clk_udp);
    while (q_exp.size() != 0 && waited < DRAIN_BUDGET) begin
      @(negedge clk_udp);
      waited++;
    end
    #1;
    left = q_exp.size();
    q_exp.delete();
  endtask

  task automatic do_reset();
    reset_udp    = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_in       = 8'h00;
    repeat (2) @(negedge clk_udp);
    reset_udp = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (taddr_out !== 34'd0) begin n_fail++; $display("FAIL reset_taddr: got %h want 0", taddr_out); end
    n_tests++; if (taddr_update_out !== 1'b0) begin n_fail++; $display("FAIL reset_taddr_update: got %b want 0", taddr_update_out); end
    n_tests++; if (self_check_out !== 1'b0) begin n_fail++; $display("FAIL reset_self_check: got %b want 0", self_check_out); end
    n_tests++; if (max_len_out !== MAXLEN_RST) begin n_fail++; $display("FAIL reset_max_len: got %h want %h", max_len_out, MAXLEN_RST); end
    n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_out); end
    n_tests++; if (err_code_out !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code_out); end
    n_tests++; if (frame_count_out !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", frame_count_out); end
  endtask

  task automatic test_set_addr();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h05, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0C};
    int left;
    expect_ev(K_TADDR, 34'h012345678);
    foreach (f[i]) send_byte(f[i]);
    exp_count++;
    n_tests++; if (taddr_out !== 34'h012345678) begin n_fail++; $display("FAIL set_addr_taddr: got %h want 012345678", taddr_out); end
    n_tests++; if (frame_count_out !== exp_count) begin n_fail++; $display("FAIL set_addr_count: got %0d want %0d", frame_count_out, exp_count); end
    drain(left);
    n_tests++; if (left != 0) begin n_fail++; $display("FAIL set_addr_pulses: got %0d outstanding want 0", left); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'hA5, 8'h03, 8'h02, 8'h04, 8'h00, 8'h05};
    int left;
    expect_ev(K_SELF, 34'd0);
    foreach (f[i]) send_byte(f[i]);
    exp_count = exp_count + 16'd2;
    n_tests++; if (max_len_out !== 16'h0400) begin n_fail++; $display("FAIL b2b_max_len: got %h want 0400", max_len_out); end
    n_tests++; if (frame_count_out !== exp_count) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", frame_count_out, exp_count); end
    drain(left);
    n_tests++; if (left != 0) begin n_fail++; $display("FAIL b2b_pulses: got %0d outstanding want 0", left); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h03};
    int left;
    expect_ev(K_ERR, 34'd1);
    foreach (f[i]) send_byte(f[i]);
    n_tests++; if (err_code_out !== 2'd1) begin n_fail++; $display("FAIL chk_err_code: got %0d want 1", err_code_out); end
    n_tests++; if (frame_count_out !== exp_count) begin n_fail++; $display("FAIL chk_count: got %0d want %0d", frame_count_out, exp_count); end
    drain(left);
    n_tests++; if (left != 0) begin n_fail++; $display("FAIL chk_pulses: got %0d outstanding want 0", left); end
  endtask

  task automatic test_oversize();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h09, 8'hA5, 8'h02, 8'h00, 8'h02};
    int left;
    expect_ev(K_ERR, 34'd2);
    expect_ev(K_SELF, 34'd0);
    send_byte(f[0]); send_byte(f[1]); send_byte(f[2]);
    n_tests++; if (err_out !== 1'b1 || err_code_out !== 2'd2) begin
      n_fail++; $display("FAIL oversize_err: got err %b code %0d want err 1 code 2", err_out, err_code_out);
    end
    for (int i = 3; i < 7; i++) send_byte(f[i]);
    exp_count++;
    n_tests++; if (frame_count_out !== exp_count) begin n_fail++; $display("FAIL oversize_next_count: got %0d want %0d", frame_count_out, exp_count); end
    drain(left);
    n_tests++; if (left != 0) begin n_fail++; $display("FAIL oversize_pulses: got %0d outstanding want 0", left); end
  endtask

  // Semantic rejects: zero max length, unknown opcode, wrong LEN for SET_ADDR
  task automatic test_illegal_cmds();
    logic [7:0] f[$] = '{8'hA5, 8'h03, 8'h02, 8'h00, 8'h00, 8'h01,
                         8'hA5, 8'h07, 8'h00, 8'h07,
                         8'hA5, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h12};
    int left;
    expect_ev(K_ERR, 34'd2);
    expect_ev(K_ERR, 34'd2);
    expect_ev(K_ERR, 34'd2);
    foreach (f[i]) send_byte(f[i]);
    n_tests++; if (max_len_out !== 16'h0400) begin n_fail++; $display("FAIL illegal_max_len: got %h want 0400", max_len_out); end
    n_tests++; if (taddr_out !== 34'h012345678) begin n_fail++; $display("FAIL illegal_taddr: got %h want 012345678", taddr_out); end
    n_tests++; if (frame_count_out !== exp_count) begin n_fail++; $display("FAIL illegal_count: got %0d want %0d", frame_count_out, exp_count); end
    drain(left);
    n_tests++; if (left != 0) begin n_fail++; $display("FAIL illegal_pulses: got %0d outstanding want 0", left); end
  endtask

  task automatic test_timeout();
    logic [7:0] f[$] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h14};
    int left;
    // Full timeout: error appears after exactly TMO idle cycles, not before
    expect_ev(K_ERR, 34'd3);
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TMO - 1) @(negedge clk_udp);
    #1;
    n_tests++; if (q_exp.size() != 1) begin n_fail++; $display("FAIL timeout_early: got %0d outstanding want 1", q_exp.size()); end
    @(negedge clk_udp);
    #1;
    n_tests++; if (err_code_out !== 2'd3 || q_exp.size() != 0) begin
      n_fail++; $display("FAIL timeout_err: got code %0d outstanding %0d want code 3 outstanding 0", err_code_out, q_exp.size());
    end
    // Parser must be back in IDLE: a fresh frame parses cleanly
    expect_ev(K_SELF, 34'd0);
    @(negedge clk_udp);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    exp_count++;
    drain(left);
    n_tests++; if (left != 0 || frame_count_out !== exp_count) begin
      n_fail++; $display("FAIL timeout_idle: got outstanding %0d count %0d want 0 and %0d", left, frame_count_out, exp_count);
    end
    // Byte landing exactly on the expiry cycle is processed, no timeout
    expect_ev(K_TADDR, 34'h10);
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TMO - 1) @(negedge clk_udp);
    foreach (f[i]) send_byte(f[i]);
    exp_count++;
    n_tests++; if (taddr_out !== 34'h10) begin n_fail++; $display("FAIL expiry_byte_taddr: got %h want 10", taddr_out); end
    drain(left);
    n_tests++; if (left != 0 || frame_count_out !== exp_count) begin
      n_fail++; $display("FAIL expiry_byte: got outstanding %0d count %0d want 0 and %0d", left, frame_count_out, exp_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h05, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0C};
    int left;
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    do_reset();
    n_tests++; if (taddr_out !== 34'd0 || max_len_out !== MAXLEN_RST) begin
      n_fail++; $display("FAIL midreset_regs: got taddr %h max_len %h want 0 and %h", taddr_out, max_len_out, MAXLEN_RST);
    end
    n_tests++; if (frame_count_out !== 16'd0 || err_code_out !== 2'd0 || err_out !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status: got count %0d code %0d err %b want 0 0 0", frame_count_out, err_code_out, err_out);
    end
    expect_ev(K_TADDR, 34'h012345678);
    foreach (f[i]) send_byte(f[i]);
    exp_count++;
    n_tests++; if (taddr_out !== 34'h012345678 || frame_count_out !== exp_count) begin
      n_fail++; $display("FAIL midreset_reparse: got taddr %h count %0d want 012345678 and %0d", taddr_out, frame_count_out, exp_count);
    end
    drain(left);
    n_tests++; if (left != 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d outstanding want 0", left); end
  endtask

  initial begin : main
    reset_udp    = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_in       = 8'h00;
    @(negedge clk_udp);
    test_reset();
    test_set_addr();
    test_back_to_back();
    test_bad_checksum();
    test_oversize();
    test_illegal_cmds();
    test_timeout();
    test_reset_mid_frame();
    repeat (4) @(negedge clk_udp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
